// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types for the APB requester: FSM state encoding,
//               protection attribute type and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef logic [2:0] prot_t;

    // Width of a counter that must reach 'limit'; a zero limit still needs
    // one bit so the counter vector stays legal.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_timer
// Description : Wait-state counter for the APB ACCESS phase. Counts enabled
//               cycles since the last clear and flags when the count equals
//               a non-zero limit. A zero limit never expires.
// Ports       : PCLK, PRESETn (sync, active-low)
//               clear   - zero the count
//               enable  - count this cycle
//               limit   - expiry value (0 = disabled)
//               expired - count == limit and limit != 0
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int CNT_W = 5
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;
    logic             w_count_en;

    // Saturate at the limit so a held-off completion cannot wrap the count.
    assign w_count_en = enable && (limit != '0) && !expired;
    assign expired    = (limit != '0) && (r_count == limit);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester
// Description : APB requester. Accepts a request on transfer/req_ready,
//               runs the APB SETUP/ACCESS sequence and returns a one-cycle
//               rsp_valid with rdata/error/timeout, which then hold until
//               the next response.
// Ports       : PCLK, PRESETn (sync, active-low)
//               request  : transfer, req_ready, write_en, waddr, wdata,
//                          strb, prot, pnse
//               response : rsp_valid, rdata, error, timeout
//               APB      : PSELx, PENABLE, PWRITE, PNSE, PADDR, PWDATA,
//                          PSTRB, PPROT, PRDATA, PREADY, PSLVERR
// Revision    : 1.0 - initial release
// ============================================================================
module apb_requester
    import apb_pkg::*;
#(
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,   // 8, 16 or 32
    parameter int  TIMEOUT = 16,   // max ACCESS wait cycles, 0 = no timeout
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    // request side
    input  logic              transfer,
    output logic              req_ready,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] strb,
    input  prot_t             prot,
    input  logic              pnse,
    // response side
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              error,
    output logic              timeout,
    // APB requester interface
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic              PNSE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [STRB_W-1:0] PSTRB,
    output prot_t             PPROT,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int               c_cnt_w = cnt_width(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    apb_state_e r_state;
    apb_state_e w_state_nxt;
    logic       w_expired;
    logic       w_done;
    logic       w_accept;

    // PREADY takes priority over the timeout in the same cycle.
    assign w_done = (r_state == ACCESS) && (PREADY || w_expired);

    // Gated by PRESETn so req_ready reads 0 while reset is held, and rises
    // in the first cycle with reset released.
    assign req_ready = PRESETn && ((r_state == IDLE) || w_done);
    assign w_accept  = transfer && req_ready;

    apb_wait_timer #(
        .CNT_W (c_cnt_w)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (r_state == SETUP),
        .enable  ((r_state == ACCESS) && !PREADY),
        .limit   (c_limit),
        .expired (w_expired)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        PSELx       = 1'b0;
        PENABLE     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSELx       = 1'b1;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                if (w_done) begin
                    w_state_nxt = w_accept ? SETUP : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request attributes: captured on accept, held until the next accept.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            PSTRB  <= '0;
            PPROT  <= '0;
            PNSE   <= 1'b0;
        end else if (w_accept) begin
            PADDR  <= waddr;
            PWDATA <= wdata;
            PWRITE <= write_en;
            PSTRB  <= write_en ? strb : '0;
            PPROT  <= prot;
            PNSE   <= pnse;
        end
    end

    // Response: pulse the cycle after completion, payload holds afterwards.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rdata     <= '0;
            error     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            rsp_valid <= w_done;
            if (w_done) begin
                error   <= PREADY ? PSLVERR : 1'b1;
                timeout <= ~PREADY;
                rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
            end
        end
    end

endmodule
`default_nettype wire
